seq_div_8bit: RTL and testbench

- Sequential restoring divider. It is the inverse-operation companion to the ALU's vedic multiplier.
- Takes an unsigned WIDTH-bit dividend and divisor and produces quotient and remainder, one bit per clock.
- Sits beside the multiplier in the 8-bit ALU datapath. The ALU controller drives it with a start/done handshake.

---
 rtl/seq_div_8bit.sv | 91 +++++++++
 tb/tb_seq_div_8bit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_div_8bit.sv
// seq_div_8bit: restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_div_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] pr, wq, dvs, dvd, a_mag, b_mag, q_res, r_res;
  logic [WIDTH:0] shifted, trial;
  logic zero, accept;
`ifdef SEQ_DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_res = zero ? '1 : (q_neg ? -wq : wq);
  assign r_res = zero ? dvd : (r_neg ? -pr : pr);
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_res = zero ? '1 : wq;
  assign r_res = zero ? dvd : pr;
`endif
  // done is registered, so a start seen alongside it is still part of this operation
  assign accept  = start && state == IDLE && !done;
  assign busy    = state != IDLE;
  assign shifted = {pr, wq[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? (divisor == '0 ? FINISH : CALC) : IDLE;
    else if (state == CALC) state_nx = cnt == '0 ? FINISH : CALC;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      pr          <= '0;
      wq          <= '0;
      dvs         <= '0;
      dvd         <= '0;
      zero        <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= state == FINISH;
      if (accept) begin
        dvd  <= dividend;
        dvs  <= b_mag;
        wq   <= a_mag;
        pr   <= '0;
        cnt  <= CW'(WIDTH - 1);
        zero <= divisor == '0;
`ifdef SEQ_DIV_SIGNED_EN
        q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg <= dividend[WIDTH-1];
`endif
      end else if (state == CALC) begin
        pr  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        wq  <= {wq[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - 1'b1;
      end else if (state == FINISH) begin
        quotient    <= q_res;
        remainder   <= r_res;
        div_by_zero <= zero;
      end
    end
  end
endmodule

// File: tb/tb_seq_div_8bit.sv
// tb_seq_div_8bit: directed checks of the sequential divider handshake and results.
module tb_seq_div_8bit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int errors = 0, checks = 0;

  seq_div_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while ((done || busy) && guard < 40) begin @(negedge clk); guard++; end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // n counts edges including the start edge; bc counts sampled busy-high cycles
  task automatic wait_done(output int n, output int bc);
    n = 1; bc = 0;
    while (!done && n < 30) begin
      bc += int'(busy);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q got=%0d want=0", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL reset_r got=%0d want=0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n, bc;
    launch(8'd100, 8'd7);
    wait_done(n, bc);
    checks += 5;
    if (n != 10) begin errors++; $display("FAIL basic_latency got=%0d want=10", n); end
    if (bc != 9) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=9", bc); end
    if (quotient !== 8'd14) begin errors++; $display("FAIL basic_q got=%0d want=14", quotient); end
    if (remainder !== 8'd2) begin errors++; $display("FAIL basic_r got=%0d want=2", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b want=0", div_by_zero); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_div_zero;
    int n, bc;
    launch(8'd55, 8'd0);
    wait_done(n, bc);
    checks += 4;
    if (n != 2) begin errors++; $display("FAIL dz_latency got=%0d want=2", n); end
    if (quotient !== 8'd255) begin errors++; $display("FAIL dz_q got=%0d want=255", quotient); end
    if (remainder !== 8'd55) begin errors++; $display("FAIL dz_r got=%0d want=55", remainder); end
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
    launch(8'd9, 8'd3);
    wait_done(n, bc);
    checks += 3;
    if (quotient !== 8'd3) begin errors++; $display("FAIL dz_next_q got=%0d want=3", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL dz_next_r got=%0d want=0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag got=%b want=0", div_by_zero); end
  endtask

  task automatic test_boundaries;
    logic [7:0] va[4] = '{8'd255, 8'd0, 8'd6, 8'd255};
    logic [7:0] vb[4] = '{8'd1, 8'd5, 8'd200, 8'd255};
    logic [7:0] vq[4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [7:0] vr[4] = '{8'd0, 8'd0, 8'd6, 8'd0};
    int n, bc;
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i]);
      wait_done(n, bc);
      checks += 2;
      if (quotient !== vq[i]) begin errors++; $display("FAIL bound_q %0d/%0d got=%0d want=%0d", va[i], vb[i], quotient, vq[i]); end
      if (remainder !== vr[i]) begin errors++; $display("FAIL bound_r %0d/%0d got=%0d want=%0d", va[i], vb[i], remainder, vr[i]); end
    end
  endtask

  task automatic test_start_busy;
    int pulses = 0, dn = 0;
    launch(8'd100, 8'd7);
    for (int n = 1; n <= 13; n++) begin
      start = (n == 3 || n == 9 || n == 10);
      dividend = 8'd50; divisor = 8'd5;
      if (done) begin pulses++; dn = n; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks += 5;
    if (pulses != 1) begin errors++; $display("FAIL busy_pulses got=%0d want=1", pulses); end
    if (dn != 10) begin errors++; $display("FAIL busy_done_at got=%0d want=10", dn); end
    if (quotient !== 8'd14) begin errors++; $display("FAIL busy_q got=%0d want=14", quotient); end
    if (remainder !== 8'd2) begin errors++; $display("FAIL busy_r got=%0d want=2", remainder); end
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_finish_start got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    launch(8'd12, 8'd4);
    wait_done(n, bc);
    checks += 2;
    if (quotient !== 8'd3) begin errors++; $display("FAIL b2b_q1 got=%0d want=3", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL b2b_r1 got=%0d want=0", remainder); end
    launch(8'd250, 8'd16);
    wait_done(n, bc);
    checks += 3;
    if (n != 10) begin errors++; $display("FAIL b2b_latency got=%0d want=10", n); end
    if (quotient !== 8'd15) begin errors++; $display("FAIL b2b_q2 got=%0d want=15", quotient); end
    if (remainder !== 8'd10) begin errors++; $display("FAIL b2b_r2 got=%0d want=10", remainder); end
  endtask

  task automatic test_reset_mid_calc;
    int n, bc;
    launch(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b want=0", done); end
    if (quotient !== 8'd0) begin errors++; $display("FAIL rmid_q got=%0d want=0", quotient); end
    if (remainder !== 8'd0) begin errors++; $display("FAIL rmid_r got=%0d want=0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_dbz got=%b want=0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
    launch(8'd200, 8'd7);
    wait_done(n, bc);
    checks += 2;
    if (quotient !== 8'd28) begin errors++; $display("FAIL rmid_next_q got=%0d want=28", quotient); end
    if (remainder !== 8'd4) begin errors++; $display("FAIL rmid_next_r got=%0d want=4", remainder); end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed;
    logic [7:0] va[3] = '{8'h9C, 8'h64, 8'h80};
    logic [7:0] vb[3] = '{8'h07, 8'hF9, 8'hFF};
    logic [7:0] vq[3] = '{8'hF2, 8'hF2, 8'h80};
    logic [7:0] vr[3] = '{8'hFE, 8'h02, 8'h00};
    int n, bc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i]);
      wait_done(n, bc);
      checks += 3;
      if (quotient !== vq[i]) begin errors++; $display("FAIL signed_q %h/%h got=%h want=%h", va[i], vb[i], quotient, vq[i]); end
      if (remainder !== vr[i]) begin errors++; $display("FAIL signed_r %h/%h got=%h want=%h", va[i], vb[i], remainder, vr[i]); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL signed_dbz %h/%h got=%b want=0", va[i], vb[i], div_by_zero); end
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_basic;
    test_div_zero;
    test_boundaries;
    test_start_busy;
    test_back_to_back;
    test_reset_mid_calc;
`ifdef SEQ_DIV_SIGNED_EN
    test_signed;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
